// File: rtl/frame_scanner_if.sv
// Handshake and pixel bus between a frame requester and frame_scanner.
// master drives start/display; slave (the scanner) drives status and pixel outputs.
interface frame_scanner_if #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 32
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic                    start;
    logic [WIDTH*HEIGHT-1:0] display;
    logic                    busy;
    logic                    done;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic [2:0]              colour;
    logic                    plot;

    modport master (
        output start, display,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  start, display,
        output busy, done, x, y, colour, plot
    );
endinterface

// File: rtl/frame_scanner.sv
// frame_scanner: snapshots the packed display bitmap on start and streams it column-major
// to vga_adapter, one pixel per clock. Optional macro FRAME_SCANNER_SKIP_UNCHANGED_EN plots only changed pixels.
module frame_scanner #(
    parameter int         WIDTH     = 16,
    parameter int         HEIGHT    = 32,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic           clock,
    input  logic           resetn,
    frame_scanner_if.slave bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int IW   = $clog2(NPIX);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [NPIX-1:0] snap_reg, snap_next;
    logic [XW-1:0]   cx_reg, cx_next;
    logic [YW-1:0]   cy_reg, cy_next;
    logic [XW-1:0]   x_reg, x_next;
    logic [YW-1:0]   y_reg, y_next;
    logic [2:0]      colour_reg, colour_next;
    logic            plot_reg, plot_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    logic [IW-1:0]   pix_idx;
    logic            pix_bit;
    logic            pix_plot;
    logic            last_pix;

    assign pix_idx  = IW'(cx_reg) * IW'(HEIGHT) + IW'(cy_reg);
    assign pix_bit  = snap_reg[pix_idx];
    assign last_pix = (cx_reg == XW'(WIDTH - 1)) && (cy_reg == YW'(HEIGHT - 1));

`ifdef FRAME_SCANNER_SKIP_UNCHANGED_EN
    logic [NPIX-1:0] prev_reg, prev_next;
    logic [NPIX-1:0] changed;
    logic            force_reg, force_next;

    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_changed
            assign changed[gi] = snap_reg[gi] ^ prev_reg[gi];
        end
    endgenerate

    // force_reg survives an abandoned frame, so the first completed frame after reset redraws everything.
    assign pix_plot = force_reg | changed[pix_idx];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_reg  <= '0;
            force_reg <= 1'b1;
        end else begin
            prev_reg  <= prev_next;
            force_reg <= force_next;
        end
    end
`else
    assign pix_plot = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            snap_reg   <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= BG_COLOUR;
            plot_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            snap_reg   <= snap_next;
            cx_reg     <= cx_next;
            cy_reg     <= cy_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (last_pix) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        snap_next   = snap_reg;
        cx_next     = cx_reg;
        cy_next     = cy_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        plot_next   = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
`ifdef FRAME_SCANNER_SKIP_UNCHANGED_EN
        prev_next   = prev_reg;
        force_next  = force_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    snap_next = bus.display;
                    cx_next   = '0;
                    cy_next   = '0;
                end
            end
            SCAN: begin
                x_next      = cx_reg;
                y_next      = cy_reg;
                colour_next = pix_bit ? FG_COLOUR : BG_COLOUR;
                plot_next   = pix_plot;
                busy_next   = 1'b1;
                // Column-major walk: row counter wraps by compare and carries into the column.
                if (cy_reg == YW'(HEIGHT - 1)) begin
                    cy_next = '0;
                    cx_next = (cx_reg == XW'(WIDTH - 1)) ? '0 : cx_reg + XW'(1);
                end else begin
                    cy_next = cy_reg + YW'(1);
                end
            end
            DONE: begin
                done_next  = 1'b1;
`ifdef FRAME_SCANNER_SKIP_UNCHANGED_EN
                prev_next  = snap_reg;
                force_next = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign bus.x      = x_reg;
    assign bus.y      = y_reg;
    assign bus.colour = colour_reg;
    assign bus.plot   = plot_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
endmodule

// File: tb/tb_frame_scanner.sv
// Scoreboard bench for frame_scanner: the stimulus side predicts every plot and done pulse
// with its cycle number; a negedge monitor pops and compares whatever the DUT presents.
module tb_frame_scanner;
    localparam int W = 16;
    localparam int H = 32;
    localparam int N = W * H;

    typedef struct {
        int x;
        int y;
        int colour;
        int cyc;
    } pix_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cycle  = 0;

    frame_scanner_if bus ();

    frame_scanner dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    int checks = 0;
    int passes = 0;

    function automatic void check(input bit ok, input string name, input string got, input string want);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %s, required %s", name, got, want);
    endfunction

    // Reference model: which pixels a frame should plot, what colour, and when.
    pix_t         exp_q[$];
    int           done_q[$];
    bit           model_force = 1'b1;
    logic [N-1:0] model_prev  = '0;

    task automatic issue_frame(input int n_edge, input logic [N-1:0] snap);
        int k = 0;
        for (int xi = 0; xi < W; xi++) begin
            for (int yi = 0; yi < H; yi++) begin
                bit b    = snap[xi * H + yi];
                bit want = 1'b1;
`ifdef FRAME_SCANNER_SKIP_UNCHANGED_EN
                want = model_force || (b != model_prev[xi * H + yi]);
`endif
                if (want) exp_q.push_back('{x: xi, y: yi, colour: (b ? 7 : 0), cyc: n_edge + 1 + k});
                k++;
            end
        end
        done_q.push_back(n_edge + N + 1);
        model_prev  = snap;
        model_force = 1'b0;
    endtask

    // Monitor
    pix_t mon_e;
    int   mon_d;
    bit   done_d = 1'b0;

    always @(negedge clock) begin
        if (resetn) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
                mon_e = exp_q.pop_front();
                check(1'b0, "missed_plot", "no plot",
                      $sformatf("(%0d,%0d) at cycle %0d", mon_e.x, mon_e.y, mon_e.cyc));
            end
            while (done_q.size() > 0 && done_q[0] < cycle) begin
                mon_d = done_q.pop_front();
                check(1'b0, "missed_done", "no done", $sformatf("done at cycle %0d", mon_d));
            end
            if (bus.plot) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
                    mon_e = exp_q.pop_front();
                    check(int'(bus.x) == mon_e.x && int'(bus.y) == mon_e.y &&
                          int'(bus.colour) == mon_e.colour && bus.busy == 1'b1, "pixel",
                          $sformatf("x=%0d y=%0d colour=%0d busy=%0b", bus.x, bus.y, bus.colour, bus.busy),
                          $sformatf("x=%0d y=%0d colour=%0d busy=1", mon_e.x, mon_e.y, mon_e.colour));
                end else begin
                    check(1'b0, "unexpected_plot",
                          $sformatf("plot x=%0d y=%0d at cycle %0d", bus.x, bus.y, cycle), "plot=0");
                end
            end
            if (bus.done) begin
                if (done_q.size() > 0 && done_q[0] == cycle) begin
                    mon_d = done_q.pop_front();
                    check(!done_d && !bus.busy && !bus.plot, "done_pulse",
                          $sformatf("prev_done=%0b busy=%0b plot=%0b", done_d, bus.busy, bus.plot),
                          "prev_done=0 busy=0 plot=0");
                    $display("frame done at cycle %0d", cycle);
                end else begin
                    check(1'b0, "unexpected_done", $sformatf("done at cycle %0d", cycle), "done=0");
                end
            end
            done_d = bus.done;
        end else begin
            done_d = 1'b0;
        end
    end

    task automatic wait_cycle(input int c);
        while (cycle < c) @(negedge clock);
    endtask

    task automatic start_frame(input logic [N-1:0] d, output int n);
        @(negedge clock);
        bus.display = d;
        bus.start   = 1'b1;
        n = cycle + 1;
        issue_frame(n, d);
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int budget = 2000;
        while ((exp_q.size() > 0 || done_q.size() > 0) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check(budget > 0, "drain_timeout",
              $sformatf("%0d plots and %0d dones outstanding", exp_q.size(), done_q.size()), "none outstanding");
    endtask

    function automatic logic [N-1:0] rand_frame();
        logic [N-1:0] d;
        for (int j = 0; j < N / 32; j++) d[j*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        logic [N-1:0] d;

        bus.start   = 1'b0;
        bus.display = '0;

        #12;
        check(bus.plot == 0 && bus.busy == 0 && bus.done == 0 && bus.x == 0 && bus.y == 0 && bus.colour == 0,
              "reset_state",
              $sformatf("plot=%0b busy=%0b done=%0b x=%0d y=%0d colour=%0d",
                        bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour), "all zero");
        @(negedge clock);
        #2 resetn = 1'b1;
        repeat (3) @(negedge clock);

        // Single set bit at (3,5)
        d = '0;
        d[3 * H + 5] = 1'b1;
        start_frame(d, n);
        drain();

        // All ones: full column-major order
        start_frame({N{1'b1}}, n);
        drain();

        // Snapshot isolation: display flips after acceptance
        start_frame('0, n);
        wait_cycle(n + 11);
        bus.display = {N{1'b1}};
        drain();

        for (int i = 0; i < 3; i++) begin
            start_frame(rand_frame(), n);
            drain();
        end

        // start pulses mid-scan and in the DONE cycle are ignored
        start_frame(rand_frame(), n);
        wait_cycle(n + 200);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_cycle(n + N);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        drain();

        // start held high: back-to-back frames with a 2-cycle gap
        d = rand_frame();
        @(negedge clock);
        bus.display = d;
        bus.start   = 1'b1;
        n = cycle + 1;
        issue_frame(n, d);
        wait_cycle(n + 300);
        bus.display = ~d;
        wait_cycle(n + N + 2);
        bus.start = 1'b0;
        issue_frame(n + N + 2, ~d);
        drain();

        // Reset during the scan at pixel 100
        start_frame(rand_frame(), n);
        wait_cycle(n + 101);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        done_q.delete();
        model_force = 1'b1;
        model_prev  = '0;
        #1;
        check(bus.plot == 0 && bus.busy == 0 && bus.done == 0 && bus.x == 0 && bus.y == 0 && bus.colour == 0,
              "reset_midscan",
              $sformatf("plot=%0b busy=%0b done=%0b x=%0d y=%0d colour=%0d",
                        bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour), "all zero");
        repeat (3) @(negedge clock);
        #2 resetn = 1'b1;
        repeat (40) @(negedge clock);
        check(bus.busy == 0 && bus.plot == 0, "idle_after_reset",
              $sformatf("busy=%0b plot=%0b", bus.busy, bus.plot), "busy=0 plot=0");

        // Unchanged-frame sequence: zeros, zeros again, then four bits set
        start_frame('0, n);
        drain();
        start_frame('0, n);
        drain();
        d = '0;
        d[0] = 1'b1;
        d[1 * H + 7] = 1'b1;
        d[9 * H + 20] = 1'b1;
        d[N - 1] = 1'b1;
        start_frame(d, n);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
